// File: rtl/mem_init_seq.sv
// rtl/mem_init_seq.sv - RAM fill sequencer with optional read-back verify
module mem_init_seq #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1,
    parameter int WR_GAP = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fill_value,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic [DATA_W-1:0] q,
    output logic              wren,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              stop,
    output logic              error,
    output logic [ADDR_W-1:0] err_addr
);

    typedef enum logic [2:0] {IDLE, WRITE, GAP, VREAD, VWAIT, DONE} state_t;

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);
    localparam bit         GAP_EN   = (WR_GAP != 0);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   lim_q, lim_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
    logic [1:0]          mode_q, mode_d;
    logic [1:0]          wcnt_q, wcnt_d;
    logic [DATA_W-1:0]   fill_q, fill_d;
    logic                error_q, error_d;
    logic                tail_q, tail_d;
    logic [ADDR_W+DATA_W-1:0] cnt_ext;
    logic [DATA_W-1:0]   expected;

    // Padding by DATA_W zeros makes one slice cover both zero-extend and truncate.
    always_comb begin
        cnt_ext  = {{DATA_W{1'b0}}, cnt_q};
        expected = mode_q[0] ? fill_q : cnt_ext[DATA_W-1:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            lim_q      <= '0;
            err_addr_q <= '0;
            mode_q     <= '0;
            wcnt_q     <= '0;
            fill_q     <= '0;
            error_q    <= 1'b0;
            tail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lim_q      <= lim_d;
            err_addr_q <= err_addr_d;
            mode_q     <= mode_d;
            wcnt_q     <= wcnt_d;
            fill_q     <= fill_d;
            error_q    <= error_d;
            tail_q     <= tail_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lim_d      = lim_q;
        err_addr_d = err_addr_q;
        mode_d     = mode_q;
        wcnt_d     = wcnt_q;
        fill_d     = fill_q;
        error_d    = error_q;
        tail_d     = tail_q;
        wren       = 1'b0;
        address    = '0;
        data       = '0;
        stop       = 1'b0;
        busy       = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d     = mode;
                    fill_d     = fill_value;
                    lim_d      = last_addr;
                    cnt_d      = '0;
                    error_d    = 1'b0;
                    err_addr_d = '0;
                    tail_d     = 1'b0;
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                wren    = 1'b1;
                address = cnt_q;
                data    = expected;
                if (GAP_EN) begin
                    // Every write, the last one included, is followed by its gap cycle.
                    cnt_d   = cnt_q + 1'b1;
                    tail_d  = (cnt_q == lim_q);
                    state_d = GAP;
                end else if (cnt_q == lim_q) begin
                    cnt_d   = '0;
                    state_d = mode_q[1] ? VREAD : DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            GAP: begin
                address = cnt_q;
                if (tail_q) begin
                    cnt_d   = '0;
                    state_d = mode_q[1] ? VREAD : DONE;
                end else begin
                    state_d = WRITE;
                end
            end
            VREAD: begin
                address = cnt_q;
                wcnt_d  = '0;
                state_d = VWAIT;
            end
            VWAIT: begin
                address = cnt_q;
                if (wcnt_q == LAT_LAST) begin
                    if ((q != expected) && !error_q) begin
                        error_d    = 1'b1;
                        err_addr_d = cnt_q;
                    end
                    if (cnt_q == lim_q) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = VREAD;
                    end
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            DONE: begin
                stop    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign error    = error_q;
    assign err_addr = err_addr_q;

endmodule
